// File: rtl/rename_register_file.sv
// Register rename table: per-register value and ROB tag, with combinational read ports
// that bypass a same-cycle matching commit.
module rename_register_file #(
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 4,
    parameter int NRD     = 4,
    localparam int REG_AW = $clog2(REG_NUM),
    localparam int CNT_W  = $clog2(REG_NUM + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    alloc_valid,
    input  logic [REG_AW-1:0]       alloc_rd,
    input  logic [ROB_W-1:0]        alloc_rob_id,
    input  logic [NRD*REG_AW-1:0]   rd_addr,
    output logic [NRD-1:0]          rd_busy,
    output logic [NRD*ROB_W-1:0]    rd_tag,
    output logic [NRD*DATA_W-1:0]   rd_value,
    input  logic                    commit_valid,
    input  logic [REG_AW-1:0]       commit_rd,
    input  logic [ROB_W-1:0]        commit_rob_id,
    input  logic [DATA_W-1:0]       commit_value,
    input  logic                    rollback,
    output logic [CNT_W-1:0]        busy_count
);

    logic [DATA_W-1:0] val_q [REG_NUM];
    logic [DATA_W-1:0] val_d [REG_NUM];
    logic [ROB_W-1:0]  tag_q [REG_NUM];
    logic [ROB_W-1:0]  tag_d [REG_NUM];
    logic [CNT_W-1:0]  count_d;
    logic              commit_en;
    logic              alloc_en;

    assign commit_en = commit_valid && (commit_rd != '0);
    assign alloc_en  = alloc_valid && (alloc_rd != '0) && (alloc_rob_id != '0) && !rollback;

    // Commit first, then rollback, then alloc: a same-register alloc wins the tag.
    always_comb begin
        val_d = val_q;
        tag_d = tag_q;
        if (commit_en) begin
            val_d[commit_rd] = commit_value;
            if (tag_q[commit_rd] == commit_rob_id) begin
                tag_d[commit_rd] = '0;
            end
        end
        if (rollback) begin
            for (int i = 0; i < REG_NUM; i++) begin
                tag_d[i] = '0;
            end
        end
        if (alloc_en) begin
            tag_d[alloc_rd] = alloc_rob_id;
        end
        count_d = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            if (tag_d[i] != '0) begin
                count_d = count_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_count <= '0;
        end else if (rdy) begin
            val_q      <= val_d;
            tag_q      <= tag_d;
            busy_count <= count_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [REG_AW-1:0] addr;
        logic              zero;
        logic              hit;

        assign addr = rd_addr[k*REG_AW +: REG_AW];
        assign zero = (addr == '0);
        // A retiring producer whose tag still owns the register resolves it this cycle.
        assign hit  = commit_en && (commit_rd == addr) && (tag_q[addr] == commit_rob_id);

        assign rd_busy[k] = !zero && !hit && (tag_q[addr] != '0);
        assign rd_tag[k*ROB_W +: ROB_W] = (zero || hit) ? '0 : tag_q[addr];
        assign rd_value[k*DATA_W +: DATA_W] = zero ? '0 : (hit ? commit_value : val_q[addr]);
    end

endmodule

// File: tb/tb_rename_register_file.sv
// Scenario bench for rename_register_file: expected reads/counts are queued when stimulus
// is driven and compared on the following falling edge.
module tb_rename_register_file;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TW = 4;
    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst, rdy;
    logic          alloc_valid;
    logic [AW-1:0] alloc_rd;
    logic [TW-1:0] alloc_rob_id;
    logic [NR*AW-1:0] rd_addr;
    logic [NR-1:0]    rd_busy;
    logic [NR*TW-1:0] rd_tag;
    logic [NR*DW-1:0] rd_value;
    logic          commit_valid;
    logic [AW-1:0] commit_rd;
    logic [TW-1:0] commit_rob_id;
    logic [DW-1:0] commit_value;
    logic          rollback;
    logic [5:0]    busy_count;

    typedef struct {
        bit          is_count;
        int          port;
        logic        b;
        logic [3:0]  t;
        logic [31:0] v;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic [31:0] mv [32];
    logic [3:0]  mq [32];

    always #5 clk = ~clk;

    rename_register_file #(
        .REG_NUM(32), .DATA_W(DW), .ROB_W(TW), .NRD(NR)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_rob_id(alloc_rob_id),
        .rd_addr(rd_addr), .rd_busy(rd_busy), .rd_tag(rd_tag), .rd_value(rd_value),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_rob_id(commit_rob_id),
        .commit_value(commit_value), .rollback(rollback), .busy_count(busy_count)
    );

    task automatic idle();
        rst = 1'b0; rdy = 1'b1; rollback = 1'b0;
        alloc_valid = 1'b0; alloc_rd = '0; alloc_rob_id = '0;
        commit_valid = 1'b0; commit_rd = '0; commit_rob_id = '0; commit_value = '0;
        rd_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic alloc(input logic [4:0] r, input logic [3:0] t);
        alloc_valid = 1'b1; alloc_rd = r; alloc_rob_id = t;
    endtask

    task automatic commit(input logic [4:0] r, input logic [3:0] t, input logic [31:0] v);
        commit_valid = 1'b1; commit_rd = r; commit_rob_id = t; commit_value = v;
    endtask

    task automatic expect_read(input int port, input logic [4:0] a, input logic b,
                               input logic [3:0] t, input logic [31:0] v, input string n);
        exp_t e;
        rd_addr[port*AW +: AW] = a;
        e.is_count = 1'b0; e.port = port; e.b = b; e.t = t; e.v = v; e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic expect_count(input int c, input string n);
        exp_t e;
        e.is_count = 1'b1; e.port = 0; e.b = 1'b0; e.t = '0; e.v = c; e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        for (int s = 0; s < 2; s++) begin
            tick();
            case (s)
                0: begin
                    rst = 1'b1; rdy = 1'b0; rollback = 1'b1;
                    alloc(5'd5, 4'd3); commit(5'd5, 4'd0, 32'hFFFF_FFFF);
                end
                default: begin
                    expect_read(0, 5'd0, 1'b0, 4'd0, 32'd0, "reset_x0");
                    expect_read(1, 5'd5, 1'b0, 4'd0, 32'd0, "reset_x5");
                    expect_read(2, 5'd31, 1'b0, 4'd0, 32'd0, "reset_x31");
                    expect_count(0, "reset_count");
                end
            endcase
            @(negedge clk);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (e.is_count) begin
                    if (busy_count !== e.v[5:0]) begin
                        miscompares++;
                        $display("FAIL %s: busy_count=%0d expected %0d", e.name, busy_count, e.v[5:0]);
                    end
                end else if ({rd_busy[e.port], rd_tag[e.port*TW +: TW], rd_value[e.port*DW +: DW]}
                             !== {e.b, e.t, e.v}) begin
                    miscompares++;
                    $display("FAIL %s: port%0d busy=%b tag=%0d value=%h expected busy=%b tag=%0d value=%h",
                             e.name, e.port, rd_busy[e.port], rd_tag[e.port*TW +: TW],
                             rd_value[e.port*DW +: DW], e.b, e.t, e.v);
                end
            end
        end
    endtask

    task automatic test_alloc();
        exp_t e;
        for (int s = 0; s < 2; s++) begin
            tick();
            case (s)
                0: begin
                    alloc(5'd5, 4'd3);
                    expect_read(0, 5'd5, 1'b0, 4'd0, 32'd0, "alloc_not_same_cycle");
                    expect_count(0, "alloc_count_pre");
                end
                default: begin
                    expect_read(0, 5'd5, 1'b1, 4'd3, 32'd0, "alloc_x5_tag3");
                    expect_count(1, "alloc_count");
                end
            endcase
            @(negedge clk);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (e.is_count) begin
                    if (busy_count !== e.v[5:0]) begin
                        miscompares++;
                        $display("FAIL %s: busy_count=%0d expected %0d", e.name, busy_count, e.v[5:0]);
                    end
                end else if ({rd_busy[e.port], rd_tag[e.port*TW +: TW], rd_value[e.port*DW +: DW]}
                             !== {e.b, e.t, e.v}) begin
                    miscompares++;
                    $display("FAIL %s: port%0d busy=%b tag=%0d value=%h expected busy=%b tag=%0d value=%h",
                             e.name, e.port, rd_busy[e.port], rd_tag[e.port*TW +: TW],
                             rd_value[e.port*DW +: DW], e.b, e.t, e.v);
                end
            end
        end
    endtask

    task automatic test_commit_bypass();
        exp_t e;
        for (int s = 0; s < 2; s++) begin
            tick();
            case (s)
                0: begin
                    commit(5'd5, 4'd3, 32'hDEAD_BEEF);
                    expect_read(0, 5'd5, 1'b0, 4'd0, 32'hDEAD_BEEF, "bypass_x5");
                    expect_read(2, 5'd0, 1'b0, 4'd0, 32'd0, "bypass_x0");
                    expect_count(1, "bypass_count_pre");
                end
                default: begin
                    expect_read(0, 5'd5, 1'b0, 4'd0, 32'hDEAD_BEEF, "commit_x5_after");
                    expect_count(0, "commit_count");
                end
            endcase
            @(negedge clk);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (e.is_count) begin
                    if (busy_count !== e.v[5:0]) begin
                        miscompares++;
                        $display("FAIL %s: busy_count=%0d expected %0d", e.name, busy_count, e.v[5:0]);
                    end
                end else if ({rd_busy[e.port], rd_tag[e.port*TW +: TW], rd_value[e.port*DW +: DW]}
                             !== {e.b, e.t, e.v}) begin
                    miscompares++;
                    $display("FAIL %s: port%0d busy=%b tag=%0d value=%h expected busy=%b tag=%0d value=%h",
                             e.name, e.port, rd_busy[e.port], rd_tag[e.port*TW +: TW],
                             rd_value[e.port*DW +: DW], e.b, e.t, e.v);
                end
            end
        end
    endtask

    task automatic test_stale_commit();
        exp_t e;
        for (int s = 0; s < 4; s++) begin
            tick();
            case (s)
                0: begin
                    alloc(5'd7, 4'd2);
                    expect_count(0, "stale_count0");
                end
                1: begin
                    alloc(5'd7, 4'd6);
                    expect_read(3, 5'd7, 1'b1, 4'd2, 32'd0, "stale_first_tag");
                    expect_count(1, "stale_count1");
                end
                2: begin
                    commit(5'd7, 4'd2, 32'h11);
                    expect_read(1, 5'd7, 1'b1, 4'd6, 32'd0, "stale_no_bypass");
                    expect_count(1, "stale_count2");
                end
                default: begin
                    expect_read(1, 5'd7, 1'b1, 4'd6, 32'h11, "stale_tag_kept");
                    expect_count(1, "stale_count3");
                end
            endcase
            @(negedge clk);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (e.is_count) begin
                    if (busy_count !== e.v[5:0]) begin
                        miscompares++;
                        $display("FAIL %s: busy_count=%0d expected %0d", e.name, busy_count, e.v[5:0]);
                    end
                end else if ({rd_busy[e.port], rd_tag[e.port*TW +: TW], rd_value[e.port*DW +: DW]}
                             !== {e.b, e.t, e.v}) begin
                    miscompares++;
                    $display("FAIL %s: port%0d busy=%b tag=%0d value=%h expected busy=%b tag=%0d value=%h",
                             e.name, e.port, rd_busy[e.port], rd_tag[e.port*TW +: TW],
                             rd_value[e.port*DW +: DW], e.b, e.t, e.v);
                end
            end
        end
    endtask

    task automatic test_alloc_commit_same_reg();
        exp_t e;
        for (int s = 0; s < 5; s++) begin
            tick();
            case (s)
                0: begin
                    alloc(5'd9, 4'd1);
                    expect_count(1, "same_count0");
                end
                1: begin
                    alloc(5'd9, 4'd4);
                    commit(5'd9, 4'd1, 32'h22);
                    expect_read(2, 5'd9, 1'b0, 4'd0, 32'h22, "same_bypass");
                    expect_count(2, "same_count1");
                end
                2: begin
                    expect_read(2, 5'd9, 1'b1, 4'd4, 32'h22, "same_alloc_wins");
                    expect_count(2, "same_count2");
                    // Writes and renames of x0 must be dropped.
                    alloc(5'd0, 4'd5);
                    commit(5'd0, 4'd0, 32'h55);
                    expect_read(3, 5'd0, 1'b0, 4'd0, 32'd0, "x0_same_cycle");
                end
                3: begin
                    alloc(5'd11, 4'd0);
                    expect_read(3, 5'd0, 1'b0, 4'd0, 32'd0, "x0_after");
                    expect_count(2, "x0_count");
                end
                default: begin
                    expect_read(0, 5'd11, 1'b0, 4'd0, 32'd0, "alloc_tag0_ignored");
                    expect_count(2, "tag0_count");
                end
            endcase
            @(negedge clk);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (e.is_count) begin
                    if (busy_count !== e.v[5:0]) begin
                        miscompares++;
                        $display("FAIL %s: busy_count=%0d expected %0d", e.name, busy_count, e.v[5:0]);
                    end
                end else if ({rd_busy[e.port], rd_tag[e.port*TW +: TW], rd_value[e.port*DW +: DW]}
                             !== {e.b, e.t, e.v}) begin
                    miscompares++;
                    $display("FAIL %s: port%0d busy=%b tag=%0d value=%h expected busy=%b tag=%0d value=%h",
                             e.name, e.port, rd_busy[e.port], rd_tag[e.port*TW +: TW],
                             rd_value[e.port*DW +: DW], e.b, e.t, e.v);
                end
            end
        end
    endtask

    task automatic test_rollback();
        exp_t e;
        for (int s = 0; s < 12; s++) begin
            tick();
            if (s < 10) begin
                alloc(5'(10 + s), 4'(s + 1));
                expect_count(2 + s, "rb_fill_count");
            end else if (s == 10) begin
                rollback = 1'b1;
                alloc(5'd3, 4'd5);
                commit(5'd10, 4'd1, 32'h77);
                expect_read(0, 5'd10, 1'b0, 4'd0, 32'h77, "rb_bypass");
                expect_read(1, 5'd19, 1'b1, 4'd10, 32'd0, "rb_pre_x19");
                expect_count(12, "rb_count_pre");
            end else begin
                expect_read(0, 5'd3, 1'b0, 4'd0, 32'd0, "rb_x3_not_renamed");
                expect_read(1, 5'd10, 1'b0, 4'd0, 32'h77, "rb_commit_value");
                expect_read(2, 5'd7, 1'b0, 4'd0, 32'h11, "rb_x7");
                expect_read(3, 5'd19, 1'b0, 4'd0, 32'd0, "rb_x19");
                expect_count(0, "rb_count");
            end
            @(negedge clk);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (e.is_count) begin
                    if (busy_count !== e.v[5:0]) begin
                        miscompares++;
                        $display("FAIL %s: busy_count=%0d expected %0d", e.name, busy_count, e.v[5:0]);
                    end
                end else if ({rd_busy[e.port], rd_tag[e.port*TW +: TW], rd_value[e.port*DW +: DW]}
                             !== {e.b, e.t, e.v}) begin
                    miscompares++;
                    $display("FAIL %s: port%0d busy=%b tag=%0d value=%h expected busy=%b tag=%0d value=%h",
                             e.name, e.port, rd_busy[e.port], rd_tag[e.port*TW +: TW],
                             rd_value[e.port*DW +: DW], e.b, e.t, e.v);
                end
            end
        end
    endtask

    task automatic test_hold_then_reset();
        exp_t e;
        for (int s = 0; s < 5; s++) begin
            tick();
            case (s)
                0: begin
                    alloc(5'd12, 4'd7);
                    expect_count(0, "hold_count0");
                end
                1: begin
                    rdy = 1'b0; rollback = 1'b1;
                    alloc(5'd13, 4'd8);
                    commit(5'd12, 4'd7, 32'h99);
                    expect_read(0, 5'd13, 1'b0, 4'd0, 32'd0, "hold_x13_pre");
                    expect_read(1, 5'd9, 1'b0, 4'd0, 32'h22, "hold_x9");
                    expect_count(1, "hold_count1");
                end
                2: begin
                    rdy = 1'b0;
                    expect_read(0, 5'd12, 1'b1, 4'd7, 32'd0, "hold_x12_frozen");
                    expect_read(1, 5'd13, 1'b0, 4'd0, 32'd0, "hold_x13_frozen");
                    expect_count(1, "hold_count2");
                end
                3: begin
                    rst = 1'b1; rdy = 1'b0;
                end
                default: begin
                    rdy = 1'b0;
                    expect_read(0, 5'd12, 1'b0, 4'd0, 32'd0, "rst_x12");
                    expect_read(1, 5'd9, 1'b0, 4'd0, 32'd0, "rst_x9");
                    expect_read(2, 5'd10, 1'b0, 4'd0, 32'd0, "rst_x10");
                    expect_read(3, 5'd7, 1'b0, 4'd0, 32'd0, "rst_x7");
                    expect_count(0, "rst_count");
                end
            endcase
            @(negedge clk);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (e.is_count) begin
                    if (busy_count !== e.v[5:0]) begin
                        miscompares++;
                        $display("FAIL %s: busy_count=%0d expected %0d", e.name, busy_count, e.v[5:0]);
                    end
                end else if ({rd_busy[e.port], rd_tag[e.port*TW +: TW], rd_value[e.port*DW +: DW]}
                             !== {e.b, e.t, e.v}) begin
                    miscompares++;
                    $display("FAIL %s: port%0d busy=%b tag=%0d value=%h expected busy=%b tag=%0d value=%h",
                             e.name, e.port, rd_busy[e.port], rd_tag[e.port*TW +: TW],
                             rd_value[e.port*DW +: DW], e.b, e.t, e.v);
                end
            end
        end
    endtask

    // Random back-to-back traffic against a behavioural model; state is all-zero on entry.
    task automatic test_back_to_back();
        exp_t        e;
        logic [4:0]  a;
        logic [3:0]  cnt;
        int          pc;
        for (int i = 0; i < 32; i++) begin
            mv[i] = '0;
            mq[i] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            tick();
            rst      = ($urandom_range(0, 60) == 0);
            rdy      = ($urandom_range(0, 7) != 0);
            rollback = ($urandom_range(0, 20) == 0);
            if ($urandom_range(0, 2) != 0) alloc(5'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) != 0) begin
                a = 5'($urandom_range(0, 7));
                cnt = ($urandom_range(0, 1) != 0) ? mq[a] : 4'($urandom_range(0, 15));
                commit(a, cnt, $urandom);
            end
            for (int p = 0; p < NR; p++) begin
                a = 5'($urandom_range(0, 8));
                if (a == 5'd0)
                    expect_read(p, a, 1'b0, 4'd0, 32'd0, $sformatf("rand_c%0d", c));
                else if (commit_valid && commit_rd == a && mq[a] == commit_rob_id)
                    expect_read(p, a, 1'b0, 4'd0, commit_value, $sformatf("rand_c%0d", c));
                else
                    expect_read(p, a, mq[a] != 4'd0, mq[a], mv[a], $sformatf("rand_c%0d", c));
            end
            pc = 0;
            for (int i = 0; i < 32; i++) if (mq[i] != 4'd0) pc++;
            expect_count(pc, $sformatf("rand_count_c%0d", c));
            @(negedge clk);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (e.is_count) begin
                    if (busy_count !== e.v[5:0]) begin
                        miscompares++;
                        $display("FAIL %s: busy_count=%0d expected %0d", e.name, busy_count, e.v[5:0]);
                    end
                end else if ({rd_busy[e.port], rd_tag[e.port*TW +: TW], rd_value[e.port*DW +: DW]}
                             !== {e.b, e.t, e.v}) begin
                    miscompares++;
                    $display("FAIL %s: port%0d busy=%b tag=%0d value=%h expected busy=%b tag=%0d value=%h",
                             e.name, e.port, rd_busy[e.port], rd_tag[e.port*TW +: TW],
                             rd_value[e.port*DW +: DW], e.b, e.t, e.v);
                end
            end
            if (rst) begin
                for (int i = 0; i < 32; i++) begin
                    mv[i] = '0;
                    mq[i] = '0;
                end
            end else if (rdy) begin
                if (commit_valid && commit_rd != 5'd0) begin
                    mv[commit_rd] = commit_value;
                    if (mq[commit_rd] == commit_rob_id) mq[commit_rd] = '0;
                end
                if (rollback) for (int i = 0; i < 32; i++) mq[i] = '0;
                if (alloc_valid && alloc_rd != 5'd0 && alloc_rob_id != 4'd0 && !rollback)
                    mq[alloc_rd] = alloc_rob_id;
            end
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_alloc();
        test_commit_bypass();
        test_stale_commit();
        test_alloc_commit_same_reg();
        test_rollback();
        test_hold_then_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
